// File: rtl/aoi222_bist_if.sv
// Controller-to-wrapper bundle for the AOI222 BIST: start/result handshake plus the cell vector and ZN return.
// The master side is the controller; the slave side is the wrapper, which owns start and the cell's ZN.
interface aoi222_bist_if #(
  parameter int ERR_W = 7
);
  logic             start;
  logic [5:0]       vec_out;
  logic             dut_zn;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [5:0]       first_fail_vec;

  modport master (
    input  start, dut_zn,
    output vec_out, busy, done, pass, err_cnt, fail_valid, first_fail_vec
  );

  modport slave (
    output start, dut_zn,
    input  vec_out, busy, done, pass, err_cnt, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/aoi222_bist_ctrl.sv
// Exhaustive AOI222 self-test: 64 vectors, each held SETTLE_CYCLES then sampled once (SETTLE_CYCLES+1 cycles per vector).
// start is ignored while busy. Define AOI222_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module aoi222_bist_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 7
) (
  input  logic           clk,
  input  logic           rst,
  aoi222_bist_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0]       LP_CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] LP_ERR_MAX  = '1;

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_vec, w_vec_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic             r_fail_vld, w_fail_vld_nxt;
  logic [5:0]       r_first, w_first_nxt;
  logic             w_golden;
  logic             w_mismatch;
  logic             w_stop;

  assign w_golden   = ~((r_vec[5] & r_vec[4]) | (r_vec[3] & r_vec[2]) | (r_vec[1] & r_vec[0]));
  assign w_mismatch = (bus.dut_zn != w_golden);

`ifdef AOI222_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_vec_nxt      = r_vec;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
    w_fail_vld_nxt = r_fail_vld;
    w_first_nxt    = r_first;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_err_nxt      = '0;
          w_fail_vld_nxt = 1'b0;
          w_first_nxt    = '0;
          w_vec_nxt      = '0;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (w_mismatch) begin
          if (r_err != LP_ERR_MAX) begin
            w_err_nxt = r_err + 1'b1;
          end
          if (!r_fail_vld) begin
            w_first_nxt    = r_vec;
            w_fail_vld_nxt = 1'b1;
          end
        end
        // vec_out freezes on the last (or failing) vector so the wrapper can read it back
        if (w_stop || (r_vec == 6'd63)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_vec_nxt   = r_vec + 6'd1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_vec      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_fail_vld <= 1'b0;
      r_first    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vec      <= w_vec_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_fail_vld <= w_fail_vld_nxt;
      r_first    <= w_first_nxt;
    end
  end

  assign bus.vec_out        = r_vec;
  assign bus.busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign bus.done           = (r_state == S_DONE);
  assign bus.pass           = (r_state == S_DONE) && (r_err == '0);
  assign bus.err_cnt        = r_err;
  assign bus.fail_valid     = r_fail_vld;
  assign bus.first_fail_vec = r_first;

endmodule

// File: tb/tb_aoi222_bist_ctrl.sv
// Bench for aoi222_bist_ctrl: behavioural cell models (good, stuck, missing pair, random flips) against a per-vector reference.
module tb_aoi222_bist_ctrl;
  localparam int S     = 2;
  localparam int EW    = 7;
  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  int          mode;
  logic [63:0] mask;
  int          n_pass;
  int          n_total;

  always #5 clk = ~clk;

  aoi222_bist_if #(.ERR_W(EW)) bif ();

  aoi222_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_W(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  function automatic logic golden(input logic [5:0] v);
    int pairs;
    pairs = 0;
    for (int p = 0; p < 3; p++) if (v[2*p] && v[2*p+1]) pairs++;
    return (pairs == 0);
  endfunction

  // 0 good, 1 stuck-0, 2 stuck-1, 3 C pair missing, 4 golden with per-vector flips from msk
  function automatic logic cell_zn(input int m, input logic [5:0] v, input logic [63:0] msk);
    case (m)
      0:       return golden(v);
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return !((v[5] && v[4]) || (v[3] && v[2]));
      default: return golden(v) ^ msk[v];
    endcase
  endfunction

  assign bif.dut_zn = cell_zn(mode, bif.vec_out, mask);

  task automatic ref_model(input int m, input logic [63:0] msk, output int err, output int first,
                           output int fvld, output int vec, output int cyc);
    err = 0; first = 0; fvld = 0; vec = 63; cyc = 64 * (S + 1);
    for (int v = 0; v < 64; v++) begin
      if (cell_zn(m, 6'(v), msk) != golden(6'(v))) begin
        err++;
        if (fvld == 0) begin first = v; fvld = 1; end
      end
    end
`ifdef AOI222_BIST_STOP_ON_FAIL_EN
    if (fvld == 1) begin err = 1; vec = first; cyc = (first + 1) * (S + 1); end
`endif
  endtask

  // Pulses start, then counts edges until done; optionally pokes start again at edge poke_at.
  task automatic do_run(input int poke_at, output int cyc, output int busy_n, output int v0,
                        output int e0, output bit tmo);
    @(negedge clk); bif.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bif.start = 1'b0;
    v0 = int'(bif.vec_out); e0 = int'(bif.err_cnt);
    cyc = 0; busy_n = 0; tmo = 1'b0;
    while (!bif.done) begin
      if (cyc >= LIMIT) begin tmo = 1'b1; break; end
      if (bif.busy) busy_n++;
      bif.start = (cyc == poke_at);
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    bif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.start = 1'b0; mode = 0; mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bif.vec_out, bif.busy, bif.done, bif.pass, bif.err_cnt, bif.fail_valid, bif.first_fail_vec} !== '0)
      $display("FAIL reset outputs: vec=%0d busy=%b done=%b pass=%b err=%0d fv=%b first=%0d, want all 0",
               bif.vec_out, bif.busy, bif.done, bif.pass, bif.err_cnt, bif.fail_valid, bif.first_fail_vec);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_sweeps();
    int e_err, e_first, e_fvld, e_vec, e_cyc, cyc, busy_n, v0, e0;
    bit tmo;
    for (int k = 0; k < 10; k++) begin
      mode = (k < 4) ? k : 4;
      mask = {$urandom(), $urandom()};
      if (k >= 7) mask = mask & {$urandom(), $urandom()} & {$urandom(), $urandom()};
      ref_model(mode, mask, e_err, e_first, e_fvld, e_vec, e_cyc);
      do_run(-1, cyc, busy_n, v0, e0, tmo);
      n_total++; if (tmo) $display("FAIL sweep%0d timeout: no done after %0d cycles", k, cyc); else n_pass++;
      n_total++; if (cyc !== e_cyc) $display("FAIL sweep%0d latency got %0d want %0d", k, cyc, e_cyc); else n_pass++;
      n_total++; if (busy_n !== e_cyc) $display("FAIL sweep%0d busy cycles got %0d want %0d", k, busy_n, e_cyc); else n_pass++;
      n_total++; if (v0 !== 0 || e0 !== 0) $display("FAIL sweep%0d start state vec=%0d err=%0d want 0/0", k, v0, e0); else n_pass++;
      n_total++; if (int'(bif.err_cnt) !== e_err) $display("FAIL sweep%0d err_cnt got %0d want %0d", k, bif.err_cnt, e_err); else n_pass++;
      n_total++; if (int'(bif.fail_valid) !== e_fvld) $display("FAIL sweep%0d fail_valid got %0d want %0d", k, bif.fail_valid, e_fvld); else n_pass++;
      n_total++; if (int'(bif.first_fail_vec) !== e_first) $display("FAIL sweep%0d first_fail_vec got %0d want %0d", k, bif.first_fail_vec, e_first); else n_pass++;
      n_total++; if (int'(bif.vec_out) !== e_vec) $display("FAIL sweep%0d vec_out got %0d want %0d", k, bif.vec_out, e_vec); else n_pass++;
      n_total++; if (bif.pass !== (e_err == 0) || bif.done !== 1'b1)
        $display("FAIL sweep%0d pass/done got %b/%b want %b/1", k, bif.pass, bif.done, (e_err == 0)); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, busy_n, v0, e0, n;
    bit tmo;
`ifdef AOI222_BIST_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 1;
`endif
    @(negedge clk); bif.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bif.start = 1'b0;
    n = 0;
    while (bif.vec_out != 6'd20 && n < LIMIT) begin @(posedge clk); n++; @(negedge clk); end
    n_total++; if (n >= LIMIT) $display("FAIL midrst reach vec 20: timeout, vec=%0d", bif.vec_out); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bif.vec_out, bif.busy, bif.done, bif.pass, bif.err_cnt, bif.fail_valid, bif.first_fail_vec} !== '0)
      $display("FAIL midrst outputs: vec=%0d busy=%b done=%b err=%0d fv=%b, want all 0",
               bif.vec_out, bif.busy, bif.done, bif.err_cnt, bif.fail_valid);
    else n_pass++;
    rst = 1'b0;
    mode = 0;
    do_run(-1, cyc, busy_n, v0, e0, tmo);
    n_total++; if (v0 !== 0 || e0 !== 0) $display("FAIL midrst restart vec=%0d err=%0d want 0/0", v0, e0); else n_pass++;
    n_total++; if (tmo || cyc !== 64 * (S + 1) || busy_n !== 64 * (S + 1))
      $display("FAIL midrst resweep latency got %0d busy %0d want %0d", cyc, busy_n, 64 * (S + 1)); else n_pass++;
    n_total++; if (bif.pass !== 1'b1) $display("FAIL midrst pass got %b want 1", bif.pass); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int cyc, busy_n, v0, e0;
    bit tmo;
    mode = 0;
    do_run(50, cyc, busy_n, v0, e0, tmo);
    n_total++; if (tmo || cyc !== 64 * (S + 1)) $display("FAIL busystart latency got %0d want %0d", cyc, 64 * (S + 1)); else n_pass++;
    n_total++; if (busy_n !== 64 * (S + 1) || v0 !== 0 || e0 !== 0)
      $display("FAIL busystart busy %0d vec0 %0d err0 %0d want %0d/0/0", busy_n, v0, e0, 64 * (S + 1)); else n_pass++;
    n_total++; if (bif.pass !== 1'b1 || bif.vec_out !== 6'd63)
      $display("FAIL busystart pass %b vec %0d want 1/63", bif.pass, bif.vec_out); else n_pass++;
  endtask

  task automatic test_rerun();
    int cyc, busy_n, v0, e0;
    bit tmo;
    mode = 2;
    do_run(-1, cyc, busy_n, v0, e0, tmo);
    n_total++; if (tmo || bif.pass !== 1'b0 || bif.first_fail_vec !== 6'd3)
      $display("FAIL rerun failing run pass %b first %0d want 0/3", bif.pass, bif.first_fail_vec); else n_pass++;
    mode = 0;
    do_run(-1, cyc, busy_n, v0, e0, tmo);
    n_total++; if (e0 !== 0 || v0 !== 0) $display("FAIL rerun cleared err %0d vec %0d want 0/0", e0, v0); else n_pass++;
    n_total++; if (tmo || cyc !== 64 * (S + 1) || busy_n !== 64 * (S + 1))
      $display("FAIL rerun latency %0d busy %0d want %0d", cyc, busy_n, 64 * (S + 1)); else n_pass++;
    n_total++; if (bif.pass !== 1'b1 || bif.err_cnt !== '0 || bif.fail_valid !== 1'b0 || bif.first_fail_vec !== 6'd0)
      $display("FAIL rerun result pass %b err %0d fv %b first %0d want 1/0/0/0",
               bif.pass, bif.err_cnt, bif.fail_valid, bif.first_fail_vec); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    bif.start = 1'b0; rst = 1'b1; mode = 0; mask = '0;
    test_reset();
    test_sweeps();
    test_reset_mid_sweep();
    test_start_while_busy();
    test_rerun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
